l2_mem_ctrl: RTL and testbench

Memory-side controller between the L2 cache and the main-memory model. It accepts L2 fill requests and dirty-line writebacks. Writebacks are held in a small coalescing write buffer. Fill requests are either forwarded from that buffer or issued as single-cycle read strobes to memory, and the block waits for `ready`. Buffered writebacks drain to memory when no fill is in flight.

---
 rtl/l2_mem_pkg.sv | 33 +++
 rtl/l2_mem_ctrl_wb_buffer.sv | 115 +++++++++++
 rtl/l2_mem_ctrl.sv | 157 +++++++++++++++
 tb/tb_l2_mem_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_mem_pkg.sv
// l2_mem_pkg: shared state encoding, block type and address helpers
// for the L2 memory-side controller.
package l2_mem_pkg;

    localparam int WORD_BITS = 32;
    localparam int BLK_WORDS = 16;
    localparam int ADDR_MAX  = 64;

    typedef logic [BLK_WORDS-1:0][WORD_BITS-1:0] block_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WR_ISSUE,
        ST_RESP
    } state_e;

    function automatic int block_bits(input int block_size);
        return $clog2(block_size);
    endfunction

    function automatic logic [ADDR_MAX-1:0] align_addr(
        input logic [ADDR_MAX-1:0] addr,
        input int                  bits
    );
        logic [ADDR_MAX-1:0] mask;
        mask = '1;
        mask = mask << bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/l2_mem_ctrl_wb_buffer.sv
// wb_buffer: coalescing writeback FIFO with a full-associative
// address match for both coalescing and read forwarding.
module wb_buffer
    import l2_mem_pkg::*;
#(
    parameter int AW    = 32,
    parameter int BW    = 512,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [AW-1:0]              push_addr,
    input  logic [BW-1:0]              push_data,
    output logic                       push_ready,
    input  logic                       pop,
    input  logic [AW-1:0]              match_addr,
    output logic [$clog2(DEPTH):0]     count,
    output logic [AW-1:0]              head_addr,
    output logic [BW-1:0]              head_data,
    output logic                       hit,
    output logic [BW-1:0]              hit_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [BW-1:0]    data_q [DEPTH];
    logic [BW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] push_hit, fwd_hit;
    logic             coal, accept, alloc;

    // The head leaving this cycle is not a coalescing target.
    always_comb begin
        push_hit = '0;
        fwd_hit  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            push_hit[i] = vld_q[i] && (addr_q[i] == push_addr)
                       && !(pop && (PW'(i) == head_q));
            fwd_hit[i]  = vld_q[i] && (addr_q[i] == match_addr);
        end
    end

    assign coal       = |push_hit;
    assign push_ready = (cnt_q < CW'(DEPTH)) || coal;
    assign accept     = push && push_ready;
    assign alloc      = accept && !coal;

    always_comb begin
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fwd_hit[i]) begin
                hit_data = hit_data | data_q[i];
            end
        end
    end

    assign hit       = |fwd_hit;
    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign count     = cnt_q;

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        vld_d  = vld_q;
        head_d = head_q;
        tail_d = tail_q;
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + 1'b1;
        end
        if (accept) begin
            if (coal) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (push_hit[i]) begin
                        data_d[i] = push_data;
                    end
                end
            end else begin
                addr_d[tail_q] = push_addr;
                data_d[tail_q] = push_data;
                vld_d[tail_q]  = 1'b1;
                tail_d         = tail_q + 1'b1;
            end
        end
        cnt_d = cnt_q + CW'(alloc) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/l2_mem_ctrl.sv
// l2_mem_ctrl: serves L2 fills from the write buffer or memory and
// drains buffered writebacks whenever no fill is in flight.
module l2_mem_ctrl
    import l2_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 16,
    parameter int WB_DEPTH   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             l2_req_valid,
    output logic                             l2_req_ready,
    input  logic [ADDR_WIDTH-1:0]            l2_req_addr,
    output logic                             l2_resp_valid,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_resp_data,
    input  logic                             wb_valid,
    output logic                             wb_ready,
    input  logic [ADDR_WIDTH-1:0]            wb_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] wb_data,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_wdata,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    input  logic                             mem_ready,
    input  logic                             mem_hit,
    output logic                             timeout_err
);

    localparam int BLOCK_BITS = block_bits(BLOCK_SIZE);
    localparam int BW         = BLOCK_SIZE * DATA_WIDTH;
    localparam int TW         = $clog2(TIMEOUT + 1);
    localparam int CW         = $clog2(WB_DEPTH) + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [BW-1:0]         resp_q, resp_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] req_al, wb_al, head_addr;
    logic [BW-1:0]         head_data, fwd_data;
    logic [CW-1:0]         buf_cnt;
    logic                  fwd_hit, push_ok, req_fire;
    logic                  in_rd_issue, in_wr_issue;

    assign req_al = ADDR_WIDTH'(align_addr(ADDR_MAX'(l2_req_addr), BLOCK_BITS));
    assign wb_al  = ADDR_WIDTH'(align_addr(ADDR_MAX'(wb_addr), BLOCK_BITS));

    assign in_rd_issue = (state_q == ST_RD_ISSUE);
    assign in_wr_issue = (state_q == ST_WR_ISSUE);

    wb_buffer #(
        .AW    (ADDR_WIDTH),
        .BW    (BW),
        .DEPTH (WB_DEPTH)
    ) u_wb (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (wb_valid),
        .push_addr  (wb_al),
        .push_data  (wb_data),
        .push_ready (push_ok),
        .pop        (in_wr_issue),
        .match_addr (req_al),
        .count      (buf_cnt),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .hit        (fwd_hit),
        .hit_data   (fwd_data)
    );

    // Handshakes are held low during reset so every output reads zero.
    assign wb_ready     = rst_n && push_ok;
    assign l2_req_ready = rst_n && (state_q == ST_IDLE)
                       && (buf_cnt != CW'(WB_DEPTH));
    assign req_fire     = l2_req_valid && l2_req_ready;

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        resp_d  = resp_q;
        timer_d = timer_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    raddr_d = req_al;
                    if (fwd_hit) begin
                        resp_d  = fwd_data;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end else if (buf_cnt != '0) begin
                    state_d = ST_WR_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                timer_d = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (mem_ready && mem_hit) begin
                    resp_d  = mem_rdata;
                    state_d = ST_RESP;
                end else if (timer_q >= TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    resp_d  = '0;
                    state_d = ST_RESP;
                end
            end
            ST_WR_ISSUE: state_d = ST_IDLE;
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            raddr_q <= '0;
            resp_q  <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            resp_q  <= resp_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (in_rd_issue) begin
            mem_addr = raddr_q;
        end
        if (in_wr_issue) begin
            mem_addr  = head_addr;
            mem_wdata = head_data;
        end
    end

    assign mem_read      = in_rd_issue;
    assign mem_write     = in_wr_issue;
    assign l2_resp_valid = (state_q == ST_RESP);
    assign l2_resp_data  = resp_q;
    assign timeout_err   = err_q;

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// tb_l2_mem_ctrl: directed vectors for the L2 memory-side controller
// against a latency-configurable memory model where mem[i] = i.
module tb_l2_mem_ctrl;
    import l2_mem_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int BS  = 16;
    localparam int BW  = BS * DW;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          l2_req_valid, l2_req_ready;
    logic [AW-1:0] l2_req_addr;
    logic          l2_resp_valid;
    logic [BW-1:0] l2_resp_data;
    logic          wb_valid, wb_ready;
    logic [AW-1:0] wb_addr;
    logic [BW-1:0] wb_data;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata, mem_rdata;
    logic          mem_read, mem_write, mem_ready, mem_hit;
    logic          timeout_err;

    l2_mem_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BLOCK_SIZE (BS),
        .WB_DEPTH   (4),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .l2_req_valid  (l2_req_valid),
        .l2_req_ready  (l2_req_ready),
        .l2_req_addr   (l2_req_addr),
        .l2_resp_valid (l2_resp_valid),
        .l2_resp_data  (l2_resp_data),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_ready     (mem_ready),
        .mem_hit       (mem_hit),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [BW-1:0] got,
                         input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] blk(input logic [AW-1:0] base);
        block_t b;
        for (int j = 0; j < BS; j++) b[j] = base + DW'(j);
        return b;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model and strobe monitor, evaluated on the falling edge.
    int            lat = 10;
    bit            never = 1'b0;
    bit            pend = 1'b0;
    int            cnt = 0;
    int            n_rd = 0;
    int            n_wr = 0;
    int            rdy_cyc = 0;
    logic [AW-1:0] rd_addr = '0;
    logic [AW-1:0] wr_addr = '0;

    always @(negedge clk) begin
        mem_ready = 1'b0;
        mem_hit   = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else if (mem_read) begin
            pend    = 1'b1;
            cnt     = lat;
            n_rd    = n_rd + 1;
            rd_addr = mem_addr;
        end else if (pend && !never) begin
            if (cnt > 1) begin
                cnt = cnt - 1;
            end else begin
                mem_ready = 1'b1;
                mem_hit   = 1'b1;
                mem_rdata = blk(rd_addr);
                rdy_cyc   = cyc;
                pend      = 1'b0;
            end
        end
        if (mem_write) begin
            n_wr    = n_wr + 1;
            wr_addr = mem_addr;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_resp(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (l2_resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("resp_wait_expired", BW'(0), BW'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int nrd0, nw;
        l2_req_valid = 1'b0;
        l2_req_addr  = '0;
        wb_valid     = 1'b0;
        wb_addr      = '0;
        wb_data      = '0;
        mem_rdata    = '0;
        mem_ready    = 1'b0;
        mem_hit      = 1'b0;
        tick();
        tick();
        check("rst_ctl", BW'({l2_req_ready, wb_ready, l2_resp_valid,
              mem_read, mem_write, timeout_err}), BW'(0));
        check("rst_resp_data", l2_resp_data, BW'(0));
        check("rst_mem_addr", BW'(mem_addr), BW'(0));
        rst_n = 1'b1;
        tick();

        // Cold miss at 0x47.
        l2_req_valid = 1'b1;
        l2_req_addr  = 'h47;
        nrd0 = n_rd;
        check("t1_req_ready", BW'(l2_req_ready), BW'(1));
        tick();
        l2_req_valid = 1'b0;
        check("t1_mem_read", BW'(mem_read), BW'(1));
        check("t1_mem_addr", BW'(mem_addr), BW'('h40));
        tick();
        check("t1_read_one_cycle", BW'(mem_read), BW'(0));
        wait_resp(60);
        check("t1_data", l2_resp_data, blk('h40));
        check("t1_resp_after_ready", BW'(cyc - rdy_cyc), BW'(1));
        check("t1_reads", BW'(n_rd - nrd0), BW'(1));

        // Writeback 0x80 then forwarded read at 0x85.
        wb_valid = 1'b1;
        wb_addr  = 'h80;
        wb_data  = blk('hA0);
        check("t2_wb_ready", BW'(wb_ready), BW'(1));
        tick();
        wb_valid     = 1'b0;
        l2_req_valid = 1'b1;
        l2_req_addr  = 'h85;
        nrd0 = n_rd;
        nw   = n_wr;
        tick();
        l2_req_valid = 1'b0;
        check("t2_resp_cycle1", BW'(l2_resp_valid), BW'(1));
        check("t2_fwd_data", l2_resp_data, blk('hA0));
        repeat (6) tick();
        check("t2_no_read", BW'(n_rd - nrd0), BW'(0));
        check("t2_drain_cnt", BW'(n_wr - nw), BW'(1));
        check("t2_drain_addr", BW'(wr_addr), BW'('h80));

        // Two writebacks to 0x100 coalesce into one write of Y.
        nw = n_wr;
        wb_valid = 1'b1;
        wb_addr  = 'h100;
        wb_data  = blk('h1000);
        tick();
        wb_data  = blk('h2000);
        tick();
        wb_valid = 1'b0;
        check("t3_count", BW'(dut.u_wb.cnt_q), BW'(1));
        check("t3_mem_write", BW'(mem_write), BW'(1));
        check("t3_wdata", mem_wdata, blk('h2000));
        repeat (5) tick();
        check("t3_one_write", BW'(n_wr - nw), BW'(1));

        // Push matching the head being issued allocates a new entry.
        wb_valid = 1'b1;
        wb_addr  = 'h140;
        wb_data  = blk('h3000);
        tick();
        wb_valid = 1'b0;
        tick();
        check("t3b_first_wdata", mem_wdata, blk('h3000));
        wb_valid = 1'b1;
        wb_data  = blk('h4000);
        check("t3b_wb_ready", BW'(wb_ready), BW'(1));
        tick();
        wb_valid = 1'b0;
        check("t3b_count", BW'(dut.u_wb.cnt_q), BW'(1));
        tick();
        check("t3b_second_write", BW'(mem_write), BW'(1));
        check("t3b_second_wdata", mem_wdata, blk('h4000));
        tick();

        // Fill the buffer during a miss; then a held request waits.
        lat = 10;
        l2_req_valid = 1'b1;
        l2_req_addr  = 'h200;
        tick();
        l2_req_valid = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            wb_valid = 1'b1;
            wb_addr  = (k == 0) ? AW'('h200) : AW'('h300 + 'h10 * (k - 1));
            wb_data  = blk(AW'('h5000 + 'h100 * k));
            tick();
        end
        wb_valid     = 1'b0;
        wb_addr      = 'h500;
        l2_req_valid = 1'b1;
        l2_req_addr  = 'h400;
        check("t4_ready_busy", BW'(l2_req_ready), BW'(0));
        wait_resp(40);
        check("t4_mem_data_kept", l2_resp_data, blk('h200));
        tick();
        check("t4_req_ready_full", BW'(l2_req_ready), BW'(0));
        check("t4_wb_ready_full", BW'(wb_ready), BW'(0));
        nw = n_wr;
        nrd0 = n_rd;
        tick();
        check("t4_drain_write", BW'(mem_write), BW'(1));
        check("t4_drain_addr", BW'(mem_addr), BW'('h200));
        check("t4_drain_data", mem_wdata, blk('h5000));
        tick();
        check("t4_req_accept", BW'(l2_req_ready), BW'(1));
        tick();
        l2_req_valid = 1'b0;
        check("t4_read_issue", BW'(mem_read), BW'(1));
        check("t4_read_addr", BW'(mem_addr), BW'('h400));
        check("t4_one_write_first", BW'(n_wr - nw), BW'(1));
        wait_resp(40);
        check("t4_data", l2_resp_data, blk('h400));
        repeat (8) tick();
        check("t4_drained", BW'(n_wr - nw), BW'(4));

        // Memory never ready: timeout after TMO RD_WAIT cycles.
        never = 1'b1;
        l2_req_valid = 1'b1;
        l2_req_addr  = 'h600;
        tick();
        l2_req_valid = 1'b0;
        repeat (20) tick();
        check("t5_err_early", BW'(timeout_err), BW'(0));
        tick();
        check("t5_err", BW'(timeout_err), BW'(1));
        check("t5_resp_valid", BW'(l2_resp_valid), BW'(1));
        check("t5_zero_data", l2_resp_data, BW'(0));
        repeat (3) tick();
        check("t5_sticky", BW'(timeout_err), BW'(1));

        // Reset during RD_WAIT with two buffered writebacks.
        l2_req_valid = 1'b1;
        l2_req_addr  = 'h700;
        tick();
        l2_req_valid = 1'b0;
        tick();
        wb_valid = 1'b1;
        wb_addr  = 'h800;
        wb_data  = blk('h8000);
        tick();
        wb_addr  = 'h810;
        tick();
        wb_valid = 1'b0;
        check("t6_count", BW'(dut.u_wb.cnt_q), BW'(2));
        rst_n = 1'b0;
        tick();
        check("t6_rst_ctl", BW'({l2_req_ready, wb_ready, l2_resp_valid,
              mem_read, mem_write, timeout_err}), BW'(0));
        check("t6_rst_addr", BW'(mem_addr), BW'(0));
        check("t6_rst_wdata", mem_wdata, BW'(0));
        check("t6_rst_resp", l2_resp_data, BW'(0));
        rst_n = 1'b1;
        never = 1'b0;
        lat   = 5;
        nw    = n_wr;
        repeat (10) tick();
        check("t6_no_write", BW'(n_wr - nw), BW'(0));
        l2_req_valid = 1'b1;
        l2_req_addr  = 'h90C;
        tick();
        l2_req_valid = 1'b0;
        check("t6_fresh_read", BW'(mem_read), BW'(1));
        check("t6_fresh_addr", BW'(mem_addr), BW'('h900));
        wait_resp(40);
        check("t6_data", l2_resp_data, blk('h900));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
